// File: rtl/debug_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : debug_pkg                                                    |
// | Description : Shared states, host command codes and helpers for the debug  |
// |               unit controller.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP      = 3'd3,
        ST_DUMP_SEND = 3'd4,
        ST_DUMP_WAIT = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_LOAD  = 8'h01;
    localparam logic [7:0]  CMD_RUN   = 8'h02;
    localparam logic [7:0]  CMD_STEP  = 8'h03;
    localparam logic [7:0]  CMD_DUMP  = 8'h04;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Number of bytes needed to carry a snapshot of the given bit width.
    function automatic int dump_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dump_serializer.sv
// +----------------------------------------------------------------------------+
// | Module      : dump_serializer                                              |
// | Description : Streams the processor snapshot out LSB-byte first, one byte  |
// |               per transmitter handshake.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module dump_serializer
    import debug_pkg::*;
#(
    parameter int DUMP_W = 2554
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_tx_done,
    input  logic [DUMP_W-1:0] i_dump,
    output logic              o_tx_start,
    output logic [7:0]        o_data,
    output logic              o_done
);

    localparam int NB    = dump_bytes(DUMP_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0] r_idx;
    logic             r_tx_start;
    logic [7:0]       r_data;
    logic [NB*8-1:0]  w_pad;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_last;

    // Final byte carries zeros above the top snapshot bit.
    always_comb begin
        w_pad               = '0;
        w_pad[DUMP_W-1:0]   = i_dump;
    end

    assign w_next_idx = r_idx + 1'b1;
    assign w_last     = (r_idx == IDX_W'(NB - 1));
    assign o_done     = i_tx_done && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_data     <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (i_start) begin
                r_idx      <= '0;
                r_data     <= w_pad[7:0];
                r_tx_start <= 1'b1;
            end else if (i_tx_done && !w_last) begin
                r_idx      <= w_next_idx;
                r_data     <= w_pad[{w_next_idx, 3'b000} +: 8];
                r_tx_start <= 1'b1;
            end
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_data     = r_data;

endmodule

`default_nettype wire

// File: rtl/debug_unit_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : debug_unit_ctrl                                              |
// | Description : Host command sequencer: program load, run/step control and   |
// |               state dump between the UART and the MIPS core.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DUMP_W = 2554
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_done,
    input  logic [7:0]        i_data,
    input  logic              i_tx_done,
    input  logic              i_halt,
    input  logic [DUMP_W-1:0] i_dump,
    output logic              o_cpu_en,
    output logic              o_cpu_reset,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_data,
    output logic [7:0]        o_data_send,
    output logic              o_tx_start,
    output logic [2:0]        o_state
);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_imem_data;
    logic              r_imem_we;
    logic              r_cpu_en;
    logic              r_cpu_reset;
    logic              w_load_end;
    logic              w_load_byte;
    logic              w_dump_start;
    logic              w_ser_tx_done;
    logic              w_ser_done;

    // The write cycle decides termination; a byte arriving then is dropped.
    assign w_load_end    = r_imem_we && ((r_imem_data == HALT_WORD) || (r_addr == '1));
    assign w_load_byte   = (r_state == ST_LOAD) && i_rx_done && !w_load_end;
    assign w_ser_tx_done = i_tx_done && (r_state == ST_DUMP_WAIT);
    assign w_dump_start  = (w_next == ST_DUMP_SEND) && (r_state != ST_DUMP_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_data)
                        CMD_LOAD: w_next = ST_LOAD;
                        CMD_RUN:  w_next = i_halt ? ST_DUMP_SEND : ST_RUN;
                        CMD_STEP: w_next = i_halt ? ST_DUMP_SEND : ST_STEP;
                        CMD_DUMP: w_next = ST_DUMP_SEND;
                        default:  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_load_end) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_next = ST_DUMP_SEND;
                end
            end
            ST_STEP:      w_next = ST_DUMP_SEND;
            ST_DUMP_SEND: w_next = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (w_ser_done) begin
                    w_next = ST_IDLE;
                end else if (i_tx_done) begin
                    w_next = ST_DUMP_SEND;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_imem_data <= '0;
            r_imem_we   <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_cpu_reset <= 1'b0;
        end else begin
            r_imem_we   <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_cpu_en    <= (w_next == ST_RUN) || (w_next == ST_STEP);
            // Address stays put through the write cycle, then advances or clears.
            if (r_imem_we) begin
                if (w_load_end) begin
                    r_addr      <= '0;
                    r_cpu_reset <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            if (w_load_byte) begin
                r_shift    <= {r_shift[15:0], i_data};
                r_byte_cnt <= r_byte_cnt + 1'b1;
                if (r_byte_cnt == 2'd3) begin
                    r_imem_we   <= 1'b1;
                    r_imem_data <= {r_shift, i_data};
                end
            end
        end
    end

    dump_serializer #(
        .DUMP_W (DUMP_W)
    ) u_dump_serializer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_dump_start),
        .i_tx_done  (w_ser_tx_done),
        .i_dump     (i_dump),
        .o_tx_start (o_tx_start),
        .o_data     (o_data_send),
        .o_done     (w_ser_done)
    );

    assign o_cpu_en    = r_cpu_en;
    assign o_cpu_reset = r_cpu_reset;
    assign o_imem_we   = r_imem_we;
    assign o_imem_addr = r_addr;
    assign o_imem_data = r_imem_data;
    assign o_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_debug_unit_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_debug_unit_ctrl                                           |
// | Description : Scoreboard bench for debug_unit_ctrl (load, run, step, dump). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_debug_unit_ctrl;
    import debug_pkg::*;

    localparam int DW = 2554;
    localparam int NB = 320;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           rx_done = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           tx_done = 1'b0;
    logic           halt = 1'b0;
    logic [DW-1:0]  dump;
    logic [NB*8-1:0] pad;

    logic           o_cpu_en, o_cpu_reset, o_imem_we, o_tx_start;
    logic [7:0]     o_imem_addr, o_data_send;
    logic [31:0]    o_imem_data;
    logic [2:0]     o_state;

    logic           rx2_done = 1'b0;
    logic [7:0]     rx2_data = 8'h00;
    logic           tx2_done = 1'b0;
    logic           halt2 = 1'b0;
    logic [15:0]    dump2 = 16'h1234;
    logic           o2_cpu_en, o2_cpu_reset, o2_imem_we, o2_tx_start;
    logic [1:0]     o2_imem_addr;
    logic [31:0]    o2_imem_data;
    logic [7:0]     o2_data_send;
    logic [2:0]     o2_state;

    debug_unit_ctrl #(.ADDR_W(8), .DUMP_W(DW)) dut (
        .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_data(rx_data),
        .i_tx_done(tx_done), .i_halt(halt), .i_dump(dump),
        .o_cpu_en(o_cpu_en), .o_cpu_reset(o_cpu_reset), .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
        .o_data_send(o_data_send), .o_tx_start(o_tx_start), .o_state(o_state)
    );

    debug_unit_ctrl #(.ADDR_W(2), .DUMP_W(16)) dut2 (
        .clk(clk), .rst(rst), .i_rx_done(rx2_done), .i_data(rx2_data),
        .i_tx_done(tx2_done), .i_halt(halt2), .i_dump(dump2),
        .o_cpu_en(o2_cpu_en), .o_cpu_reset(o2_cpu_reset), .o_imem_we(o2_imem_we),
        .o_imem_addr(o2_imem_addr), .o_imem_data(o2_imem_data),
        .o_data_send(o2_data_send), .o_tx_start(o2_tx_start), .o_state(o2_state)
    );

    always #5 clk = ~clk;

    assign pad = {{(NB*8-DW){1'b0}}, dump};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    logic [33:0] exp_wr2[$];
    int          exp_burst[$];
    int          exp_crst = 0;
    int          tx_seen = 0;
    int          wr2_seen = 0;
    int          run_len = 0;

    logic [7:0] load_bytes [12] = '{8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h80, 8'h40, 8'hC0, 8'h20,
                                    8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Monitors: pop the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (rst) begin
            if (o_tx_start) begin
                tx_seen++;
                if (exp_tx.size() == 0) unexpected("tx_byte", {24'h0, o_data_send});
                else chk("tx_byte", {24'h0, o_data_send}, {24'h0, exp_tx.pop_front()});
            end
            if (o_imem_we) begin
                if (exp_wr.size() == 0) unexpected("imem_write", o_imem_data);
                else begin
                    logic [39:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {24'h0, o_imem_addr}, {24'h0, e[39:32]});
                    chk("wr_data", o_imem_data, e[31:0]);
                end
            end
            if (o_cpu_en) run_len++;
            else if (run_len > 0) begin
                if (exp_burst.size() == 0) unexpected("cpu_en_burst", run_len);
                else chk("cpu_en_len", run_len, exp_burst.pop_front());
                run_len = 0;
            end
            if (o_cpu_reset) begin
                if (exp_crst == 0) unexpected("cpu_reset", 1);
                else begin
                    exp_crst--;
                    chk("crst_state_addr", {21'h0, o_state, o_imem_addr}, 32'h0);
                end
            end
            if (o2_imem_we) begin
                wr2_seen++;
                if (exp_wr2.size() == 0) unexpected("lim_write", o2_imem_data);
                else begin
                    logic [33:0] e2;
                    e2 = exp_wr2.pop_front();
                    chk("lim_wr_addr", {30'h0, o2_imem_addr}, {30'h0, e2[33:32]});
                    chk("lim_wr_data", o2_imem_data, e2[31:0]);
                end
            end
            if (o2_tx_start) unexpected("lim_tx_start", {24'h0, o2_data_send});
            if (o2_cpu_en) unexpected("lim_cpu_en", 1);
        end
    end

    // Transmitter model: answers each request with tx_done five cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_start && rst) begin
                repeat (5) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_done = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_done = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(posedge clk); #1 rx2_done = 1'b1; rx2_data = b;
        @(posedge clk); #1 rx2_done = 1'b0;
    endtask

    task automatic push_dump();
        for (int k = 0; k < NB; k++) exp_tx.push_back(pad[k*8 +: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (o_state != 3'd0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(name, {29'h0, o_state}, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_en"},    {31'h0, o_cpu_en},    32'h0);
        chk({tag, "_cpu_reset"}, {31'h0, o_cpu_reset}, 32'h0);
        chk({tag, "_imem_we"},   {31'h0, o_imem_we},   32'h0);
        chk({tag, "_tx_start"},  {31'h0, o_tx_start},  32'h0);
        chk({tag, "_addr"},      {24'h0, o_imem_addr}, 32'h0);
        chk({tag, "_data"},      o_imem_data,          32'h0);
        chk({tag, "_send"},      {24'h0, o_data_send}, 32'h0);
        chk({tag, "_state"},     {29'h0, o_state},     32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DW; i++) dump[i] = (((i * 7 + 3) % 5) < 2);
        dump[7:0]       = 8'hA5;
        dump[DW-1:DW-2] = 2'b11;

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("rst");
        rst = 1'b1;

        // Program load terminated by the halt word
        exp_wr.push_back({8'd0, 32'h01020304});
        exp_wr.push_back({8'd1, 32'h8040C020});
        exp_wr.push_back({8'd2, 32'hFFFFFFFF});
        exp_crst = 1;
        send(CMD_LOAD);
        for (int i = 0; i < 12; i++) send(load_bytes[i]);
        repeat (5) @(negedge clk);
        chk("load_state", {29'h0, o_state}, 32'h0);
        chk("load_wr_left", exp_wr.size(), 0);
        chk("load_crst_left", exp_crst, 0);

        // Unknown command is ignored
        send(8'h07);
        repeat (5) @(negedge clk);
        chk("ign_state", {29'h0, o_state}, 32'h0);

        // Run for ten cycles with stray received bytes, then dump
        push_dump();
        exp_burst.push_back(10);
        send(CMD_RUN);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            rx_done = (i % 2 == 1) && (i < 9);
            rx_data = CMD_LOAD;
            if (i == 5) chk("run_state", {29'h0, o_state}, 32'h2);
            if (i == 9) halt = 1'b1;
        end
        wait_idle("run_dump_idle", 6000);
        halt = 1'b0;
        chk("run_tx_left", exp_tx.size(), 0);
        chk("run_burst_left", exp_burst.size(), 0);
        chk("last_byte_pad", {24'h0, pad[NB*8-1 -: 8]}, 32'h3);

        // Single step
        push_dump();
        exp_burst.push_back(1);
        send(CMD_STEP);
        wait_idle("step_dump_idle", 6000);
        chk("step_tx_left", exp_tx.size(), 0);
        chk("step_burst_left", exp_burst.size(), 0);

        // Step with halt already high: dump only
        halt = 1'b1;
        push_dump();
        send(CMD_STEP);
        wait_idle("sthalt_dump_idle", 6000);
        halt = 1'b0;
        chk("sthalt_tx_left", exp_tx.size(), 0);
        chk("sthalt_run_len", run_len, 0);

        // Reset in the middle of a dump, then restart from byte 0
        tx_seen = 0;
        push_dump();
        send(CMD_DUMP);
        begin
            int guard;
            guard = 0;
            while (tx_seen < 101 && guard < 3000) begin
                @(negedge clk); #1;
                guard++;
            end
        end
        chk("mid_reached", {31'h0, tx_seen >= 101}, 32'h1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("mid");
        exp_tx.delete();
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        push_dump();
        send(CMD_DUMP);
        wait_idle("restart_dump_idle", 6000);
        chk("restart_tx_left", exp_tx.size(), 0);

        // Address limit on the 2-bit instance; 0x04 in the exit cycle is dropped
        for (int w = 0; w < 4; w++)
            exp_wr2.push_back({w[1:0], 8'h10 + 8'(w), 8'h20, 8'h30, 8'h40 + 8'(w)});
        send2(CMD_LOAD);
        for (int w = 0; w < 4; w++) begin
            send2(8'h10 + 8'(w));
            send2(8'h20);
            send2(8'h30);
            if (w < 3) send2(8'h40 + 8'(w));
        end
        @(posedge clk); #1 rx2_done = 1'b1; rx2_data = 8'h43;
        @(posedge clk); #1 rx2_data = CMD_DUMP;
        @(posedge clk); #1 rx2_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("lim_exit_state", {29'h0, o2_state}, 32'h0);
        send2(8'h55); send2(8'h66); send2(8'h77); send2(8'h88);
        repeat (5) @(negedge clk);
        chk("lim_state", {29'h0, o2_state}, 32'h0);
        chk("lim_wr_left", exp_wr2.size(), 0);
        chk("lim_wr_count", wr2_seen, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
